// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// It tracks a shadow copy of the EX/MEM/WB destination info and produces registered ALU operand selects.
module fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_valid,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic [1:0]       id_srcb_ctrl,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       alu_srca_fwd,
  output logic [1:0]       alu_srcb_fwd,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic [CNT_W-1:0] stall_count
);

  logic       ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_valid, mem_reg_write, mem_mem_read;
  logic [4:0] mem_rd;
  logic       wb_valid, wb_reg_write, wb_mem_read;
  logic [4:0] wb_rd;

  logic       ex_prod, mem_prod, load_use, load_ex;
  logic [1:0] next_a, next_b;

  // Register 0 is hard-wired, so a slot writing it is never a producer.
  assign ex_prod  = ex_valid & ex_reg_write & (ex_rd != 5'd0);
  assign mem_prod = mem_valid & mem_reg_write & (mem_rd != 5'd0);

  assign load_use = ex_prod & ex_mem_read & id_valid &
                    ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  assign bubble_ex = flush | load_use;
  assign stall_id  = load_use & ~flush;
  assign load_ex   = id_valid & ~bubble_ex;

  // Selects for the instruction entering EX; a load in EX is never a MEM-stage source.
  always_comb begin
    next_a = 2'd0;
    next_b = 2'd0;
    if (load_ex) begin
      if (id_uses_rs) begin
        if (ex_prod && !ex_mem_read && (ex_rd == id_rs))
          next_a = 2'd1;
        else if (mem_prod && (mem_rd == id_rs))
          next_a = 2'd2;
      end
      if (id_uses_rt && (id_srcb_ctrl == 2'd0)) begin
        if (ex_prod && !ex_mem_read && (ex_rd == id_rt))
          next_b = 2'd1;
        else if (mem_prod && (mem_rd == id_rt))
          next_b = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rd         <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= 5'd0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_reg_write  <= 1'b0;
      wb_mem_read   <= 1'b0;
      alu_srca_fwd  <= 2'd0;
      alu_srcb_fwd  <= 2'd0;
      stall_count   <= '0;
    end else if (!hold) begin
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      wb_mem_read   <= mem_mem_read;
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      ex_valid      <= load_ex;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      alu_srca_fwd  <= next_a;
      alu_srcb_fwd  <= next_b;
      if (stall_id && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: forwarding selects, load-use stalls, flush, hold, saturation and reset.
// A second instance with a 2-bit counter shares all inputs to exercise saturation.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        id_valid, id_reg_write, id_mem_read;
  logic [1:0]  id_srcb_ctrl;
  logic        flush, hold;
  logic [1:0]  alu_srca_fwd, alu_srcb_fwd, alu_srca_fwd2, alu_srcb_fwd2;
  logic        stall_id, bubble_ex, stall_id2, bubble_ex2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int tests_run = 0;
  int tests_failed = 0;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_srcb_ctrl(id_srcb_ctrl), .flush(flush), .hold(hold),
    .alu_srca_fwd(alu_srca_fwd), .alu_srcb_fwd(alu_srcb_fwd),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .stall_count(stall_count)
  );

  fwd_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_srcb_ctrl(id_srcb_ctrl), .flush(flush), .hold(hold),
    .alu_srca_fwd(alu_srca_fwd2), .alu_srcb_fwd(alu_srcb_fwd2),
    .stall_id(stall_id2), .bubble_ex(bubble_ex2), .stall_count(stall_count2)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic uses_rs,
                               input logic [4:0] rt, input logic uses_rt, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic [1:0] srcb);
    id_valid     = valid;
    id_rs        = rs;
    id_uses_rs   = uses_rs;
    id_rt        = rt;
    id_uses_rt   = uses_rt;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_srcb_ctrl = srcb;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0);
    checkOutput("reset_stall", 16'(stall_id), 16'd0);
    checkOutput("reset_bubble", 16'(bubble_ex), 16'd0);
    checkOutput("reset_a", 16'(alu_srca_fwd), 16'd0);
    checkOutput("reset_b", 16'(alu_srcb_fwd), 16'd0);
    checkOutput("reset_cnt", stall_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU result forwarded from MEM, then gone
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 2'd0);
    stepClock();
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 2'd0);
    checkOutput("alu_no_stall", 16'(stall_id), 16'd0);
    stepClock();
    checkOutput("alu_fwd_a", 16'(alu_srca_fwd), 16'd1);
    checkOutput("alu_fwd_b", 16'(alu_srcb_fwd), 16'd0);
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0);
    stepClock();
    checkOutput("alu_fwd_a_next", 16'(alu_srca_fwd), 16'd0);

    // load-use: one stall, then WB-stage forward
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 2'd1);
    stepClock();
    checkOutput("lw_a", 16'(alu_srca_fwd), 16'd0);
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 2'd0);
    checkOutput("lu_stall", 16'(stall_id), 16'd1);
    checkOutput("lu_bubble", 16'(bubble_ex), 16'd1);
    stepClock();
    checkOutput("lu_cnt", stall_count, 16'd1);
    checkOutput("lu_cnt_sat", 16'(stall_count2), 16'd1);
    checkOutput("lu_bubble_b", 16'(alu_srcb_fwd), 16'd0);
    checkOutput("lu_stall_gone", 16'(stall_id), 16'd0);
    stepClock();
    checkOutput("lu_fwd_b", 16'(alu_srcb_fwd), 16'd2);
    checkOutput("lu_fwd_a", 16'(alu_srca_fwd), 16'd0);
    checkOutput("lu_cnt_after", stall_count, 16'd1);

    // double match on r4: MEM stage wins
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 2'd0);
    stepClock();
    checkOutput("r9_fwd_a", 16'(alu_srca_fwd), 16'd1);
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 2'd0);
    stepClock();
    checkOutput("r4b_a", 16'(alu_srca_fwd), 16'd0);
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0, 2'd0);
    stepClock();
    checkOutput("dbl_a", 16'(alu_srca_fwd), 16'd1);
    checkOutput("dbl_b", 16'(alu_srcb_fwd), 16'd1);

    // writes to r0 never forward
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'd0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 2'd0);
    stepClock();
    checkOutput("r0_a", 16'(alu_srca_fwd), 16'd0);
    checkOutput("r0_b", 16'(alu_srcb_fwd), 16'd0);

    // immediate operand suppresses B forward
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0, 2'd1);
    stepClock();
    checkOutput("imm_b", 16'(alu_srcb_fwd), 16'd0);

    // flush beats load-use
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 2'd1);
    stepClock();
    applyStimulus(1'b1, 5'd13, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1, 1'b0, 2'd0);
    checkOutput("pre_flush_stall", 16'(stall_id), 16'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", 16'(stall_id), 16'd0);
    checkOutput("flush_bubble", 16'(bubble_ex), 16'd1);
    stepClock();
    flush = 1'b0;
    checkOutput("flush_cnt", stall_count, 16'd1);
    checkOutput("flush_a", 16'(alu_srca_fwd), 16'd0);
    applyStimulus(1'b1, 5'd13, 1'b1, 5'd12, 1'b1, 5'd15, 1'b1, 1'b0, 2'd0);
    checkOutput("post_flush_stall", 16'(stall_id), 16'd0);
    stepClock();
    checkOutput("post_flush_a", 16'(alu_srca_fwd), 16'd2);
    checkOutput("post_flush_b", 16'(alu_srcb_fwd), 16'd0);

    // hold freezes selects and slots for three edges
    applyStimulus(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0, 2'd0);
    stepClock();
    checkOutput("pre_hold_a", 16'(alu_srca_fwd), 16'd1);
    hold = 1'b1;
    applyStimulus(1'b1, 5'd16, 1'b1, 5'd15, 1'b1, 5'd17, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++) stepClock();
    checkOutput("hold_a", 16'(alu_srca_fwd), 16'd1);
    checkOutput("hold_b", 16'(alu_srcb_fwd), 16'd0);
    hold = 1'b0;
    stepClock();
    checkOutput("unhold_a", 16'(alu_srca_fwd), 16'd1);
    checkOutput("unhold_b", 16'(alu_srcb_fwd), 16'd2);

    // stall under hold does not count
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 2'd1);
    stepClock();
    applyStimulus(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 2'd0);
    hold = 1'b1;
    #1;
    checkOutput("hold_lu_stall", 16'(stall_id), 16'd1);
    stepClock();
    checkOutput("hold_lu_cnt", stall_count, 16'd1);
    checkOutput("hold_lu_still", 16'(stall_id), 16'd1);
    hold = 1'b0;
    stepClock();
    checkOutput("hold_lu_cnt2", stall_count, 16'd2);
    stepClock();
    checkOutput("hold_lu_fwd", 16'(alu_srca_fwd), 16'd2);

    // three more load-use stalls: wide counter reaches 5, 2-bit counter pins at 3
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 2'd1);
      stepClock();
      applyStimulus(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 2'd0);
      stepClock();
      stepClock();
      checkOutput("loop_fwd", 16'(alu_srca_fwd), 16'd2);
    end
    checkOutput("cnt_wide", stall_count, 16'd5);
    checkOutput("cnt_sat", 16'(stall_count2), 16'd3);

    // reset asserted in the middle of a stall
    applyStimulus(1'b1, 5'd21, 1'b1, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 2'd1);
    stepClock();
    checkOutput("pre_rst_a", 16'(alu_srca_fwd), 16'd1);
    applyStimulus(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 2'd0);
    checkOutput("pre_rst_stall", 16'(stall_id), 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_stall", 16'(stall_id), 16'd0);
    checkOutput("rst_bubble", 16'(bubble_ex), 16'd0);
    checkOutput("rst_a", 16'(alu_srca_fwd), 16'd0);
    checkOutput("rst_cnt", stall_count, 16'd0);
    checkOutput("rst_cnt_sat", 16'(stall_count2), 16'd0);
    #1;
    rst_n = 1'b1;
    stepClock();
    checkOutput("post_rst_stall", 16'(stall_id), 16'd0);
    checkOutput("post_rst_a", 16'(alu_srca_fwd), 16'd0);
    checkOutput("post_rst_cnt", stall_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the stall-event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-005 SHALL have ports id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have port id_rd  input  5  ID destination register, after RegDst selection.
REQ-007 SHALL have ports id_valid, id_reg_write, id_mem_read  input  1 each  ID holds a real instruction / writes a register / is a load.
REQ-008 SHALL have port id_srcb_ctrl  input  2  ALU_SrcB_ctrl that the ID instruction will use in EX (0 = B register, 1 = ex, 2 = snex).
REQ-009 SHALL have ports flush  input  1  (taken branch: kill the ID instruction) and hold  input  1  (external freeze, e.g. memory wait).
REQ-010 SHALL have ports alu_srca_fwd, alu_srcb_fwd  output  2 each  EX operand-forwarding selects (0 = none, 1 = Fwd_mem, 2 = Fwd_wb).
REQ-011 SHALL have ports stall_id  output  1  (freeze PC, IF/ID) and bubble_ex  output  1  (ID/EX loads a NOP).
REQ-012 SHALL have port stall_count  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-013 SHALL keep a shadow pipeline of three slots, EX, MEM and WB; each slot holds valid, rd, reg_write, mem_read.
REQ-014 SHALL treat a slot as a producer only if valid=1, reg_write=1 and rd!=0; register 0 never forwards and never stalls.
REQ-015 SHALL assert stall_id=1 and bubble_ex=1 combinationally in the same cycle when all of these hold: the EX slot is a producer with mem_read=1, id_valid=1, and (id_uses_rs and id_rs==EX.rd) or (id_uses_rt and id_rt==EX.rd).
REQ-016 SHALL drive bubble_ex=1 and stall_id=0 when flush=1; flush has priority over the load-use stall.
REQ-017 SHALL, on each edge with hold=0, advance the slots: WB<=MEM, MEM<=EX, EX<=ID fields; EX.valid SHALL be loaded 0 when bubble_ex=1 or id_valid=0.
REQ-018 SHALL, on each edge with hold=1, keep every slot, alu_srca_fwd, alu_srcb_fwd and stall_count unchanged; stall_id and bubble_ex SHALL still be evaluated but have no state effect.
REQ-019 SHALL register alu_srca_fwd/alu_srcb_fwd on the same advancing edge that loads the EX slot, so the selects apply to the instruction newly in EX.
REQ-020 SHALL compute the A select for that instruction at the edge as: 1 if the old EX slot (becoming MEM) is a producer with mem_read=0 and rd==id_rs; else 2 if the old MEM slot (becoming WB) is a producer and rd==id_rs; else 0; the select is 0 when id_uses_rs=0.
REQ-021 SHALL apply the same rule to rt for the B select, but force alu_srcb_fwd=0 whenever id_srcb_ctrl!=0 (immediate operand).
REQ-022 SHALL load both selects as 0 when the EX slot is loaded as a bubble.
REQ-023 SHALL give the MEM-stage source priority over the WB-stage source on a double match.
REQ-024 SHALL increment stall_count by 1 on each advancing edge with a load-use stall (REQ-015) and flush=0, saturating at all ones.
REQ-025 SHALL hold each load-use stall for exactly one advancing cycle; after the bubble, a consumer of a load receives select 2.

Reset
REQ-026 SHALL, while rst_n=0, immediately clear all slot valid bits, alu_srca_fwd=0, alu_srcb_fwd=0 and stall_count=0; stall_id and bubble_ex then follow REQ-015/016 with empty slots (0 unless flush=1).
REQ-027 SHALL, on reset asserted mid-stall, drop the stall immediately and resume with an empty shadow pipeline on the first edge after rst_n rises.

Verification
REQ-028 SHALL test: add r3 in ID, next ID reads rs=3 with srcb_ctrl=0 -> after the edge, alu_srca_fwd=1, then 0 on the following edge.
REQ-029 SHALL test: lw r5, then the next instruction reads rt=5 with srcb_ctrl=0 -> stall_id=1 and bubble_ex=1 for one cycle, stall_count=1, then alu_srcb_fwd=2.
REQ-030 SHALL test: r4 written by both the MEM and WB producers, consumer reads rs=4 -> alu_srca_fwd=1; and a consumer of rd=0 -> both selects 0.
REQ-031 SHALL test: rt matches with srcb_ctrl=1 -> alu_srcb_fwd=0; flush during a load-use condition -> stall_id=0, bubble_ex=1, stall_count unchanged.
REQ-032 SHALL test: hold=1 for 3 cycles in mid-sequence -> selects and slots frozen; with CNT_W=2, 4 stalls -> stall_count stays 3.
REQ-033 SHALL test: rst_n pulled low during a stall -> outputs 0 asynchronously and stall_count=0.
